// File: rtl/aes_pkg.sv
// Shared AES definitions: controller FSM encoding, round constants and the
// forward S-box used by the final-round datapath.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  localparam int AES_ROUNDS = 10;
  localparam int RC_W       = 4;

  // Row n of the table holds S-box entries 16*n .. 16*n+15, first entry in the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

endpackage

// File: rtl/final_round.sv
// Last AES round without MixColumns: SubBytes, ShiftRows, then AddRoundKey.
// Byte i of the state sits in bits [127-8i -: 8], column-major (i = 4*col + row).
module final_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] result_o
);

  // Row r rotates left by r columns, so output (row r, col c) takes input column (c+r) mod 4.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = 127 - 8*(4*c + r);
      localparam int SRC = 127 - 8*(4*((c + r) % 4) + r);
      assign result_o[DST -: 8] = sbox(state_i[SRC -: 8]) ^ key_i[DST -: 8];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption sequencer: drives an external round stage for rounds 1..9,
// performs the final round locally and presents the registered ciphertext.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            ready,
  input  logic [127:0]    pt,
  input  logic [127:0]    key,
  output logic [RC_W-1:0] rc,
  output logic [127:0]    rnd_data,
  output logic [127:0]    rnd_key,
  input  logic [127:0]    rnd_out,
  input  logic [127:0]    rnd_key_in,
  output logic [127:0]    ct,
  output logic            done
);

  localparam logic [3:0]      LAST_WAIT = 4'(ROUND_LAT - 1);
  localparam logic [RC_W-1:0] LAST_RC   = RC_W'(AES_ROUNDS - 1);

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [3:0]      wait_q, wait_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    ct_q, ct_d;
  logic [127:0]    final_res;
  logic            accept;
  logic            round_end;

  final_round u_final_round (
    .state_i  (data_q),
    .key_i    (rnd_key_in),
    .result_o (final_res)
  );

  // ready_q is only ever set while idle, so it doubles as the accept qualifier.
  assign accept    = start && ready_q;
  assign round_end = (wait_q == LAST_WAIT);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    rc_d    = rc_q;
    wait_d  = wait_q;
    data_d  = data_q;
    key_d   = key_q;
    ct_d    = ct_q;

    case (state_q)
      ST_IDLE: begin
        ready_d = !accept;
        if (accept) begin
          state_d = ST_ROUND;
          data_d  = pt ^ key;
          key_d   = key;
          rc_d    = RC_W'(1);
          wait_d  = 4'd0;
        end
      end
      ST_ROUND: begin
        if (round_end) begin
          data_d = rnd_out;
          key_d  = rnd_key_in;
          rc_d   = rc_q + RC_W'(1);
          wait_d = 4'd0;
          if (rc_q == LAST_RC) state_d = ST_FINAL;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_FINAL: begin
        // Park the ciphertext in the state register; ct only moves on the done edge.
        if (round_end) begin
          data_d  = final_res;
          rc_d    = '0;
          wait_d  = 4'd0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_DONE: begin
        ct_d    = data_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are cleared too, so an aborted operation leaves nothing behind.
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      rc_q    <= '0;
      wait_q  <= 4'd0;
      data_q  <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      rc_q    <= rc_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign rc       = rc_q;
  assign ct       = ct_q;
  assign rnd_data = data_q;
  assign rnd_key  = key_q;

endmodule
